// File: rtl/input_buffer_slave.sv
// Input feature-map buffer behind an AXI4 slave port.
// The bus master fills and reads the buffer with INCR bursts.
// Only one transaction is in flight at a time.
// The accelerator datapath reads words through a local port that never stalls the bus.
module input_buffer_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  // write address
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  // write data
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  // write response
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  // read address
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  // read data
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  // local datapath read port
  input  logic                lcl_en,
  input  logic [IDX_W-1:0]    lcl_addr,
  output logic [DATA_W-1:0]   lcl_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int B  = (NB > 1) ? $clog2(NB) : 0;
  localparam int LO = IDX_W + B;  // first address bit above the word index

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]  id_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       len_reg;
  logic [8:0]       cnt_reg;      // one extra bit so overlong bursts cannot alias onto len
  logic             err_reg;
  logic [1:0]       bresp_reg;
  logic             prio_w_reg;   // 1: write wins the next simultaneous request

  logic [DATA_W-1:0] mem [DEPTH];

  // Burst sizes and types are fixed to full-width INCR; low address bits select bytes only.
  logic unused_sigs;
  assign unused_sigs = ^{awsize, awburst, arsize, arburst, awaddr, araddr};

  // Address decode and range check for both address channels
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic [31:0]      aw_last_idx, ar_last_idx;
  logic             aw_err, ar_err;

  assign aw_idx      = awaddr[LO-1:B];
  assign ar_idx      = araddr[LO-1:B];
  assign aw_last_idx = 32'(aw_idx) + 32'(awlen);
  assign ar_last_idx = 32'(ar_idx) + 32'(arlen);
  assign aw_err      = ((awaddr >> LO) != '0) || (aw_last_idx > 32'(DEPTH - 1));
  assign ar_err      = ((araddr >> LO) != '0) || (ar_last_idx > 32'(DEPTH - 1));

  // Round-robin grant: a lone request always wins, a tie goes to the favoured channel
  logic grant_w, grant_r;
  assign grant_w = awvalid && (!arvalid || prio_w_reg);
  assign grant_r = arvalid && !grant_w;

  logic last_beat;
  assign last_beat = (cnt_reg == {1'b0, len_reg});

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next = state_reg;
    awready    = 1'b0;
    arready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    rvalid     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        awready = grant_w;
        arready = grant_r;
        if (grant_w) begin
          state_next = S_WDATA;
        end else if (grant_r) begin
          state_next = S_RDATA;
        end
      end
      S_WDATA: begin
        wready = 1'b1;
        if (wvalid && wlast) begin
          state_next = S_WRESP;
        end
      end
      S_WRESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_next = S_IDLE;
        end
      end
      S_RDATA: begin
        rvalid = 1'b1;
        if (rready && last_beat) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Transaction context: latched at the address handshake, advanced per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_reg     <= '0;
      idx_reg    <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      bresp_reg  <= RESP_OKAY;
      prio_w_reg <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_w) begin
            id_reg     <= awid;
            idx_reg    <= aw_idx;
            len_reg    <= awlen;
            err_reg    <= aw_err;
            cnt_reg    <= '0;
            prio_w_reg <= 1'b0;
          end else if (grant_r) begin
            id_reg     <= arid;
            idx_reg    <= ar_idx;
            len_reg    <= arlen;
            err_reg    <= ar_err;
            cnt_reg    <= '0;
            prio_w_reg <= 1'b1;
          end
        end
        S_WDATA: begin
          if (wvalid) begin
            idx_reg <= idx_reg + IDX_W'(1);
            if (cnt_reg != '1) begin
              cnt_reg <= cnt_reg + 9'd1;
            end
            if (wlast) begin
              // A burst that ends early (or late) is reported but its beats stay written
              bresp_reg <= (err_reg || !last_beat) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_RDATA: begin
          if (rready) begin
            idx_reg <= idx_reg + IDX_W'(1);
            if (cnt_reg != '1) begin
              cnt_reg <= cnt_reg + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-lane merge of the incoming beat over the currently stored word
  logic [DATA_W-1:0] cur_word, merged_word;
  logic              mem_we;

  assign cur_word = mem[idx_reg];
  assign mem_we   = (state_reg == S_WDATA) && wvalid && !err_reg &&
                    (cnt_reg <= {1'b0, len_reg});

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      assign merged_word[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : cur_word[gi*8 +: 8];
    end
  endgenerate

  // Buffer storage: contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_reg] <= merged_word;
    end
  end

  // Local read port: registered, sees the pre-write value on a same-cycle collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcl_rdata <= '0;
    end else if (lcl_en) begin
      lcl_rdata <= mem[lcl_addr];
    end
  end

  // Response payloads are driven only while their channel is valid
  assign bid   = (state_reg == S_WRESP) ? id_reg : '0;
  assign bresp = (state_reg == S_WRESP) ? bresp_reg : RESP_OKAY;
  assign rid   = (state_reg == S_RDATA) ? id_reg : '0;
  assign rdata = (state_reg == S_RDATA && !err_reg) ? cur_word : '0;
  assign rresp = (state_reg == S_RDATA && err_reg) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = (state_reg == S_RDATA) && last_beat;

endmodule

// File: tb/tb_input_buffer_slave.sv
// Scoreboard bench for input_buffer_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever a response channel is valid.
`timescale 1ns/1ps
module tb_input_buffer_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 8;
  localparam int DEPTH  = 1024;
  localparam int IDX_W  = 10;

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast, wvalid, wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic              lcl_en;
  logic [IDX_W-1:0]  lcl_addr;
  logic [DATA_W-1:0] lcl_rdata;

  input_buffer_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .lcl_en(lcl_en), .lcl_addr(lcl_addr), .lcl_rdata(lcl_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake never occurred, required within cycle budget", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every valid cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (bvalid) begin
        if (bq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected: got bvalid=1, required no response");
        end else begin
          chk("bid", bid, bq[0].id);
          chk("bresp", bresp, bq[0].resp);
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL r_unexpected: got rvalid=1, required no response");
        end else begin
          chk("rid", rid, rq[0].id);
          chk("rdata", rdata, rq[0].data);
          chk("rresp", rresp, rq[0].resp);
          chk("rlast", rlast, rq[0].last);
          if (rready) void'(rq.pop_front());
        end
      end
    end
  end

  function automatic bit addr_err(input logic [31:0] addr, input int len);
    int idx = int'((addr >> 2) % DEPTH);
    return (addr >= 32'(4 * DEPTH)) || (idx + len > DEPTH - 1);
  endfunction

  task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs = 0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = awready;
      tick();
    end
    awvalid = 1'b0;
    if (!hs) tmo("aw_handshake");
  endtask

  task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs = 0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = arready;
      tick();
    end
    arvalid = 1'b0;
    if (!hs) tmo("ar_handshake");
  endtask

  task automatic w_phase(input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1); wvalid = 1'b1;
      @(negedge clk);
      chk("wready", wready, 1);
      tick();
      wvalid = 1'b0; wlast = 1'b0;
    end
  endtask

  task automatic b_phase();
    bit hs = 0;
    @(negedge clk);
    chk("bvalid_after_wlast", bvalid, 1);
    tick();
    repeat ($urandom_range(0, 2)) tick();
    bready = 1'b1;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = bvalid;
      tick();
    end
    bready = 1'b0;
    if (!hs) tmo("b_handshake");
  endtask

  task automatic r_phase(input int nbeats, input bit lcl);
    int got = 0;
    bit done = 0;
    bit first = 1;
    bit lp = 0;
    int la = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      rready = ($urandom_range(0, 3) != 0);
      if (lcl) begin
        lp = 1'($urandom_range(0, 1));
        la = $urandom_range(0, DEPTH - 1);
        lcl_en = lp;
        lcl_addr = la[IDX_W-1:0];
      end
      @(negedge clk);
      if (first) begin
        chk("rvalid_cycle1", rvalid, 1);
        first = 0;
      end
      if (rvalid && rready) begin
        got++;
        if (rlast) done = 1;
      end
      tick();
      if (lcl && lp) chk("lcl_rdata", lcl_rdata, model[la]);
    end
    rready = 1'b0;
    lcl_en = 1'b0;
    if (!done) tmo("r_rlast");
    chk("r_beat_count", got, nbeats);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int nb, input bit gaps);
    b_exp_t e;
    int idx = int'((addr >> 2) % DEPTH);
    bit err = addr_err(addr, len);
    for (int b = 0; b < nb; b++) begin
      if (!err && b <= len) begin
        for (int j = 0; j < 4; j++) begin
          if (ws[b][j]) model[idx + b][8*j +: 8] = wd[b][8*j +: 8];
        end
      end
    end
    e.id = id;
    e.resp = (err || nb != len + 1) ? 2'b10 : 2'b00;
    bq.push_back(e);
    $display("write id=%0h addr=%08h len=%0d beats=%0d resp=%0d", id, addr, len, nb, e.resp);
    aw_phase(id, addr, 8'(len));
    w_phase(nb, gaps);
    b_phase();
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len, input bit lcl);
    r_exp_t e;
    int idx = int'((addr >> 2) % DEPTH);
    bit err = addr_err(addr, len);
    for (int b = 0; b <= len; b++) begin
      e.id = id;
      e.data = err ? 32'h0 : model[idx + b];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (b == len);
      rq.push_back(e);
    end
    $display("read  id=%0h addr=%08h len=%0d err=%0d", id, addr, len, err);
    ar_phase(id, addr, 8'(len));
    r_phase(len + 1, lcl);
  endtask

  // Both address channels raised together; the expected winner completes its transaction
  task automatic arb(input bit exp_w, input logic [7:0] id, input logic [31:0] addr);
    bit gw, gr;
    b_exp_t be;
    r_exp_t re;
    int idx = int'((addr >> 2) % DEPTH);
    wd[0] = $urandom; ws[0] = 4'hF;
    awid = id; awaddr = addr; awlen = 8'd0; awvalid = 1'b1;
    arid = id + 8'd1; araddr = addr; arlen = 8'd0; arvalid = 1'b1;
    @(negedge clk);
    gw = awready;
    gr = arready;
    chk("arb_aw_grant", gw, exp_w);
    chk("arb_ar_grant", gr, !exp_w);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    $display("arb   both valid, granted %s", gw ? "write" : (gr ? "read" : "none"));
    if (gw) begin
      model[idx] = wd[0];
      be.id = id; be.resp = 2'b00;
      bq.push_back(be);
      w_phase(1, 0);
      b_phase();
    end else if (gr) begin
      re.id = id + 8'd1; re.data = model[idx]; re.resp = 2'b00; re.last = 1'b1;
      rq.push_back(re);
      r_phase(1, 0);
    end else begin
      tmo("arb_grant");
    end
  endtask

  function automatic logic [31:0] rand_addr(input int len);
    int r = $urandom_range(0, 19);
    int idx;
    if (r == 0) return (32'($urandom_range(1, 16'hFFFF)) << 16) | 32'($urandom_range(0, 4095));
    if (r == 1 && len > 0) idx = $urandom_range(DEPTH - len, DEPTH - 1);
    else idx = $urandom_range(0, DEPTH - 1 - len);
    return 32'(idx * 4 + $urandom_range(0, 3));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_word;
    b_exp_t be;
    r_exp_t re;
    rst = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; lcl_en = 1'b0; lcl_addr = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_readies", {awready, arready, wready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid, rlast}, 3'b000);
    chk("rst_ids", {bid, rid}, 16'h0);
    chk("rst_resps", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_lcl_rdata", lcl_rdata, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Arbitration right after reset: W, R, W
    arb(1'b1, 8'h10, 32'h20);
    arb(1'b0, 8'h12, 32'h20);
    arb(1'b1, 8'h14, 32'h24);

    // Fill the whole buffer so every later read has a known reference
    for (int s = 0; s < DEPTH / 256; s++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      do_write(8'h20 + 8'(s), 32'(s * 1024), 255, 256, 0);
    end

    // Single write / read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(8'h11, 32'h10, 0, 1, 0);
    do_read(8'h22, 32'h10, 0, 0);

    // Burst with partial strobe over all-ones
    for (int b = 0; b < 4; b++) begin wd[b] = 32'hFFFFFFFF; ws[b] = 4'hF; end
    do_write(8'h30, 32'h0, 3, 4, 0);
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    ws[2] = 4'h3;
    do_write(8'h31, 32'h0, 3, 4, 1);
    do_read(8'h32, 32'h0, 3, 0);

    // Range errors
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(8'h33, 32'((DEPTH - 2) * 4), 3, 4, 0);
    do_read(8'h34, 32'((DEPTH - 2) * 4), 1, 0);
    do_read(8'h35, 32'h0001_0000, 0, 0);
    do_read(8'h36, 32'h0001_0040, 2, 0);

    // Early wlast
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(8'h44, 32'h100, 3, 2, 0);
    do_read(8'h45, 32'h100, 3, 0);

    // Local port collision with an AXI write to the same word
    old_word = model[7];
    be.id = 8'h50; be.resp = 2'b00;
    bq.push_back(be);
    aw_phase(8'h50, 32'(7 * 4), 8'd0);
    wdata = 32'h000000A5; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    lcl_en = 1'b1; lcl_addr = 10'd7;
    @(negedge clk);
    chk("lcl_coll_wready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    model[7] = 32'h000000A5;
    chk("lcl_old_data", lcl_rdata, old_word);
    tick();
    lcl_en = 1'b0;
    chk("lcl_new_data", lcl_rdata, 32'h000000A5);
    $display("local collision write idx=7 data=a5 old=%08h", old_word);
    b_phase();
    do_read(8'h55, 32'h400, 7, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int len = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 30) : $urandom_range(0, 7);
      logic [31:0] a = rand_addr(len);
      if ($urandom_range(0, 1) == 0) begin
        int nb = (len > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, len) : len + 1;
        for (int b = 0; b < nb; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
        do_write(8'($urandom), a, len, nb, 1);
      end else begin
        do_read(8'($urandom), a, len, 1);
      end
    end

    // Reset in the middle of a read burst
    for (int b = 0; b < 8; b++) begin
      re.id = 8'h60; re.data = model[16 + b]; re.resp = 2'b00; re.last = (b == 7);
      rq.push_back(re);
    end
    ar_phase(8'h60, 32'(16 * 4), 8'd7);
    rready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rq.delete();
    rready = 1'b0;
    $display("reset asserted after two read beats");
    @(negedge clk);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rlast_rdata", {rlast, rdata}, 33'h0);
    chk("midrst_rid", rid, 8'h0);
    tick();
    rst = 1'b1;
    tick();
    do_read(8'h61, 32'(16 * 4), 7, 1);
    wd[0] = $urandom; ws[0] = 4'hF;
    do_write(8'h62, 32'h200, 0, 1, 0);
    do_read(8'h63, 32'h200, 0, 0);

    repeat (3) tick();
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
